// File: rtl/dmem_responder.sv
// Multi-cycle 64-bit data memory responder with valid/ready request and response channels.
// Optional byte-strobe stores are enabled by defining DMEM_STRB_EN.
module dmem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef DMEM_STRB_EN
  input  logic [DATA_WIDTH/8-1:0] req_strb,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_err_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef DMEM_STRB_EN
  logic [NB-1:0]           strb_q;
`endif

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    src_idle;
  logic                    c_write;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic [NB-1:0]           c_strb;
  logic [IDX_W-1:0]        c_idx;
  logic                    c_err;
  logic                    commit;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rdata_d;

  // With LATENCY=1 the commit happens on the accepting edge, so it must use the live request.
  always_comb begin
    src_idle = (state_q == IDLE);
    c_write  = src_idle ? req_write : wr_q;
    c_addr   = src_idle ? req_addr  : addr_q;
    c_wdata  = src_idle ? req_wdata : wdata_q;
`ifdef DMEM_STRB_EN
    c_strb   = src_idle ? req_strb  : strb_q;
`else
    c_strb   = '1;
`endif
    c_idx    = c_addr[3 +: IDX_W];
    c_err    = (c_addr[2:0] != 3'b000) || (|c_addr[ADDR_WIDTH-1:3+IDX_W]);
    commit   = (src_idle && req_valid && (LATENCY == 1)) ||
               ((state_q == WAIT) && (cnt_q == 4'd0));
    mem_we   = commit && c_write && !c_err;
    rdata_d  = (c_write || c_err) ? '0 : mem[c_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef DMEM_STRB_EN
      strb_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
`ifdef DMEM_STRB_EN
            strb_q      <= req_strb;
`endif
            req_ready_q <= 1'b0;
            if (commit) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= c_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= c_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses, a monitor checks handshakes.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
`ifdef DMEM_STRB_EN
  logic [7:0]  req_strb;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] r;
    logic        e;
  } exp_t;
  exp_t sb[$];

  dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_STRB_EN
    .req_strb   (req_strb),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.r);
        chk("resp_err", {63'd0, resp_err}, {63'd0, e.e});
      end
    end
  end

  // All driver actions happen 1 time unit after a rising edge.
  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d, input logic early);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("req_ready_before_send", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = early;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'h0;
    req_wdata  = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic wait_resp();
    int k;
    k = 0;
    while (!resp_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("latency", 64'(k), 64'(LAT));
  endtask

  task automatic complete(input logic [63:0] er, input logic ee, input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, er);
      chk("hold_err", {63'd0, resp_err}, {63'd0, ee});
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_rdata", resp_rdata, 64'd0);
    chk("post_err", {63'd0, resp_err}, 64'd0);
    chk("post_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] er, input logic ee, input int hold, input logic early);
    sb.push_back('{r: er, e: ee});
    send(w, a, d, early);
    wait_resp();
    complete(er, ee, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_resp_err"}, {63'd0, resp_err}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
    resp_ready = 1'b0;
`ifdef DMEM_STRB_EN
    req_strb   = 8'hFF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load, aligned in-range
    xact(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 0, 1'b0);
    xact(1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, 1'b0);
    // Misaligned store must not disturb word 0x10
    xact(1'b1, 64'h13, 64'h1, 64'h0, 1'b1, 0, 1'b0);
    xact(1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, 1'b0);
    xact(1'b0, 64'h4, 64'h0, 64'h0, 1'b1, 0, 1'b0);
    // Range boundary: last word ok, first word past the end errors
    xact(1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0, 1'b0);
    xact(1'b0, 64'h7F8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0);
    xact(1'b0, 64'h800, 64'h0, 64'h0, 1'b1, 0, 1'b0);
    xact(1'b0, 64'h1_0000_0000_0010, 64'h0, 64'h0, 1'b1, 0, 1'b0);
    // Backpressure and early resp_ready
    xact(1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5, 1'b0);
    xact(1'b0, 64'h7F8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b1);

    // Reset in WAIT of a store: memory must keep its old value
    xact(1'b1, 64'h20, 64'h0, 64'h0, 1'b0, 0, 1'b0);
    send(1'b1, 64'h20, 64'h55, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 64'h20, 64'h0, 64'h0, 1'b0, 0, 1'b0);

    // Reset in RESP of a store: the committed write must persist
    send(1'b1, 64'h28, 64'hA5, 1'b0);
    wait_resp();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_resp");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 64'h28, 64'h0, 64'hA5, 1'b0, 0, 1'b0);

`ifdef DMEM_STRB_EN
    req_strb = 8'hFF;
    xact(1'b1, 64'h8, 64'h11223344_55667788, 64'h0, 1'b0, 0, 1'b0);
    req_strb = 8'h0F;
    xact(1'b1, 64'h8, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 0, 1'b0);
    req_strb = 8'h00;
    xact(1'b0, 64'h8, 64'h0, 64'h11223344_FFFFFFFF, 1'b0, 0, 1'b0);
    req_strb = 8'hFF;
`else
    xact(1'b1, 64'h8, 64'h11223344_55667788, 64'h0, 1'b0, 0, 1'b0);
    xact(1'b1, 64'h8, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 0, 1'b0);
    xact(1'b0, 64'h8, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port: a multi-cycle 64-bit data memory with a valid/ready request channel and a valid/ready response channel.
- The CPU core is the initiator; this block accepts one load or store at a time, waits a programmable latency, then returns read data or a write acknowledge.
- Replaces the single-cycle data memory when the core moves to a stall-capable memory interface.

Parameters:
- DATA_WIDTH, 64, width of data words; fixed at 64 for this design.
- ADDR_WIDTH, 64, width of the byte address.
- DEPTH, 256, number of 64-bit words; power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - FSM is in IDLE; latency counter is 0.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on a clock edge where req_valid=1.
  - On acceptance, register req_write, req_addr and req_wdata; go to WAIT with counter=LATENCY-1.
  - If LATENCY=1, go straight to the commit step.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, perform the commit step and go to RESP.
- Commit step:
  - Word index = addr[3 +: log2(DEPTH)].
  - err=1 if addr[2:0]!=0 or (addr>>3)>=DEPTH.
  - Load, no error: resp_rdata=mem[index].
  - Store, no error: mem[index]=wdata; resp_rdata=0.
  - Error: no memory write; resp_rdata=0; resp_err=1.
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable until the handshake.
  - When resp_ready=1, the handshake completes on that edge: resp_valid, resp_rdata and resp_err go to 0 and the FSM returns to IDLE.
  - req_ready rises on the cycle after the handshake. There are no back-to-back acceptances.
- Latency: resp_valid is first high in the cycle LATENCY clocks after the accepting edge.
- Inputs are ignored while not in IDLE. Only one transaction is ever outstanding.
- resp_ready held high early: the response still appears for at least one cycle.
- Reset mid-operation: the transaction is dropped.
  - A store not yet committed never writes memory.
  - A store already committed stays written.
- A load following a store to the same address returns the stored value.

Optional Feature:
- Macro: DMEM_STRB_EN.
- Defined:
  - Adds input port req_strb, width DATA_WIDTH/8. Bit i enables byte i of a store.
  - Bytes with strobe 0 keep their old value.
  - Loads ignore req_strb.
- Undefined:
  - No req_strb port; every store writes the full 64-bit word.

Test Plan:
- Load after store, LATENCY=2: store 0xDEADBEEF_CAFEF00D to addr 0x10, then load 0x10 -> first resp_valid 2 cycles after each accept; store response rdata=0 err=0; load response rdata=0xDEADBEEF_CAFEF00D.
- Misaligned access: store 0x1 to addr 0x13 -> resp_err=1; subsequent load of 0x10 still returns the earlier value.
- Out of range, DEPTH=256: load of addr 0x800 -> resp_err=1, resp_rdata=0.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable, req_ready=0 throughout; raise resp_ready -> req_ready=1 on the next cycle.
- Reset mid-operation: assert reset in WAIT of a store of 0x55 to addr 0x20 (previous contents 0x0) -> outputs return to reset values immediately; a later load of 0x20 returns 0x0.
- DMEM_STRB_EN: word 0x11223344_55667788 at addr 0x8, store 0xFFFFFFFF_FFFFFFFF with strb 0x0F -> load returns 0x11223344_FFFFFFFF.
